// File: rtl/booth_arb_pkg.sv
// Shared FSM state type and sizing helpers for booth_mult_arbiter and its core.
package booth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int id_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // The step counter holds W..0: W Booth steps, then one terminal cycle at zero.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/booth_radix2_core.sv
// Iterative radix-2 Booth multiplier: one add/sub plus arithmetic shift per step.
// The accumulator is W+1 bits so the most-negative multiplicand cannot overflow it.
module booth_radix2_core #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic [2*W-1:0] prod
);

  logic [W:0]   acc;
  logic [W:0]   m_ext;
  logic [W:0]   sum;
  logic [W-1:0] q;
  logic         q_m1;

  always_comb begin
    // NOTE: assigning a default before the case keeps this purely combinational (no latch).
    sum = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
  end

  // NOTE: datapath registers are reset as well, so the product reads zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      m_ext <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
    end else if (load) begin
      acc   <= '0;
      m_ext <= {mcand[W-1], mcand};
      q     <= mplier;
      q_m1  <= 1'b0;
    end else if (step) begin
      // NOTE: non-blocking updates so every register sees the pre-step values.
      acc   <= {sum[W], sum[W:1]};
      q     <= {sum[0], q[W-1:1]};
      q_m1  <= q[0];
    end
  end

  assign prod = {acc[W-1:0], q};

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one radix-2 Booth core among N_REQ requesters; round-robin by default,
// fixed lowest-index priority when BOOTH_ARB_FIXED_PRIO_EN is defined.
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter  int W     = 32,
  parameter  int N_REQ = 4,
  localparam int ID_W  = id_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [2*W-1:0]     rsp_prod
);

  localparam int CNT_W = cnt_w(W);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_vld;
  logic             accept;
  logic [W-1:0]     sel_x;
  logic [W-1:0]     sel_y;

`ifdef BOOTH_ARB_FIXED_PRIO_EN
  always_comb begin
    cand      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ID_W'(i);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end
`else
  logic [ID_W-1:0] ptr;

  // Scan farthest-to-nearest so the first valid index after ptr is the one left standing.
  always_comb begin
    cand      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(ptr) + k) % N_REQ);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ptr <= ID_W'(N_REQ - 1);
    else if (accept) ptr <= grant_idx;
  end
`endif

  // Gated by rst so no requester sees a grant while the block is held in reset.
  assign accept = rst && (state == IDLE) && grant_vld;

  always_comb begin
    req_ready = '0;
    sel_x     = '0;
    sel_y     = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_x = req_x[i*W +: W];
        sel_y = req_y[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      id_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= BUSY;
          cnt   <= CNT_W'(W);
          id_q  <= grant_idx;
        end
        BUSY: if (cnt == '0) state <= DONE;
              else           cnt   <= cnt - 1'b1;
        DONE: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  booth_radix2_core #(.W(W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   ((state == BUSY) && (cnt != '0)),
    .mcand  (sel_x),
    .mplier (sel_y),
    .prod   (rsp_prod)
  );

  assign rsp_valid = (state == DONE);
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed self-checking bench for booth_mult_arbiter (W=32, N_REQ=4).
// Define BOOTH_ARB_FIXED_PRIO_EN for both RTL and bench to exercise the fixed-priority build.
module tb_booth_mult_arbiter;

  localparam int W     = 32;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int LAT   = W + 1;

  logic               clk;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_x;
  logic [N_REQ*W-1:0] req_y;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [2*W-1:0]     rsp_prod;

  int n_checks = 0;
  int n_fails  = 0;

  booth_mult_arbiter #(.W(W), .N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input int idx, input logic [W-1:0] x, input logic [W-1:0] y);
    req_x[idx*W +: W] = x;
    req_y[idx*W +: W] = y;
    req_valid[idx]    = 1'b1;
  endtask

  // Returns at negedge+1 once any masked req_ready bit is high, or ok=0 after a bound.
  task automatic wait_ready(input logic [N_REQ-1:0] mask, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if ((req_ready & mask) != '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Counts rising edges until rsp_valid is seen 1 ns after an edge.
  task automatic wait_rsp(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Issues one request from idx, deasserts after accept, checks latency, id and product.
  task automatic single_req(input string name, input int idx, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [2*W-1:0] exp_p);
    bit ok;
    int lat;
    @(negedge clk);
    drive(idx, x, y);
    wait_ready(N_REQ'(1) << idx, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL %s_grant: req_ready=%b never granted requester %0d", name, req_ready, idx);
    end
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
    wait_rsp(lat, ok);
    n_checks++;
    if (!ok || lat != LAT) begin
      n_fails++;
      $display("FAIL %s_latency: got %0d edges (seen=%0b) expected %0d", name, lat, ok, LAT);
    end
    n_checks++;
    if (rsp_prod !== exp_p) begin
      n_fails++;
      $display("FAIL %s_prod: got %0d expected %0d", name, $signed(rsp_prod), $signed(exp_p));
    end
    n_checks++;
    if (rsp_id !== ID_W'(idx)) begin
      n_fails++;
      $display("FAIL %s_id: got %0d expected %0d", name, rsp_id, idx);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;
    #2;
    n_checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_prod !== '0) begin
      n_fails++;
      $display("FAIL reset_outputs: ready=%b valid=%b id=%0d prod=%0d expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_prod);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single;
    single_req("single", 0, 32'sd2, -32'sd5, -64'sd10);
  endtask

  task automatic test_corners;
    single_req("corner_max_min", 2, 32'sd2147483647, 32'h8000_0000, -64'sd4611686016279904256);
    single_req("corner_min_min", 3, 32'h8000_0000, 32'h8000_0000, 64'sd4611686018427387904);
  endtask

`ifndef BOOTH_ARB_FIXED_PRIO_EN
  task automatic test_round_robin;
    logic [W-1:0]   xs [N_REQ] = '{32'sd12, -32'sd20, -32'sd3, 32'sd100};
    logic [W-1:0]   ys [N_REQ] = '{32'sd5, -32'sd11, 32'sd21, 32'sd0};
    logic [2*W-1:0] ps [N_REQ] = '{64'sd60, 64'sd220, -64'sd63, 64'sd0};
    int order [5] = '{0, 1, 2, 3, 0};
    bit ok;
    int lat;
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) drive(i, xs[i], ys[i]);
    for (int g = 0; g < 5; g++) begin
      wait_ready('1, ok);
      n_checks++;
      if (!ok || req_ready !== (N_REQ'(1) << order[g])) begin
        n_fails++;
        $display("FAIL rr_grant%0d: req_ready=%b expected one-hot %0d", g, req_ready, order[g]);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (req_ready !== '0) begin
        n_fails++;
        $display("FAIL rr_busy_ready%0d: req_ready=%b expected 0", g, req_ready);
      end
      wait_rsp(lat, ok);
      n_checks++;
      if (!ok || rsp_id !== ID_W'(order[g]) || rsp_prod !== ps[order[g]]) begin
        n_fails++;
        $display("FAIL rr_rsp%0d: id=%0d prod=%0d expected id=%0d prod=%0d", g, rsp_id,
                 $signed(rsp_prod), order[g], $signed(ps[order[g]]));
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask
`endif

  task automatic test_backpressure;
    bit ok;
    int lat;
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1, 32'sd7, -32'sd3);
    wait_ready(4'b0010, ok);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    drive(2, -32'sd9, 32'sd9);
    wait_rsp(lat, ok);
    n_checks++;
    if (!ok || rsp_prod !== -64'sd21 || rsp_id !== 2'd1) begin
      n_fails++;
      $display("FAIL bp_first: id=%0d prod=%0d expected id=1 prod=-21", rsp_id, $signed(rsp_prod));
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_prod !== -64'sd21 || rsp_id !== 2'd1 || req_ready !== '0) begin
        n_fails++;
        $display("FAIL bp_hold%0d: valid=%b id=%0d prod=%0d ready=%b expected 1/1/-21/0000",
                 c, rsp_valid, rsp_id, $signed(rsp_prod), req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
      n_fails++;
      $display("FAIL bp_release: valid=%b ready=%b expected 0 and 0100", rsp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    wait_rsp(lat, ok);
    n_checks++;
    if (!ok || lat != LAT || rsp_prod !== -64'sd81 || rsp_id !== 2'd2) begin
      n_fails++;
      $display("FAIL bp_second: lat=%0d id=%0d prod=%0d expected lat=%0d id=2 prod=-81",
               lat, rsp_id, $signed(rsp_prod), LAT);
    end
  endtask

  task automatic test_reset_mid_busy;
    bit ok;
    bit seen;
    int lat;
    @(negedge clk);
    drive(1, 32'sd65535, 32'sd1);
    wait_ready(4'b0010, ok);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_prod !== '0) begin
      n_fails++;
      $display("FAIL midrst_outputs: ready=%b valid=%b id=%0d prod=%0d expected all 0",
               req_ready, rsp_valid, rsp_id, rsp_prod);
    end
    req_valid = '0;
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fails++;
      $display("FAIL midrst_no_rsp: rsp_valid=1 seen expected 0 after aborted multiply");
    end
    drive(0, 32'sd3, 32'sd4);
    drive(2, 32'sd5, 32'sd6);
    wait_ready(4'b0101, ok);
    n_checks++;
    if (!ok || req_ready !== 4'b0001) begin
      n_fails++;
      $display("FAIL midrst_first_grant: req_ready=%b expected 0001", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    wait_rsp(lat, ok);
    n_checks++;
    if (!ok || rsp_prod !== 64'sd12 || rsp_id !== 2'd0) begin
      n_fails++;
      $display("FAIL midrst_rsp0: id=%0d prod=%0d expected id=0 prod=12", rsp_id, $signed(rsp_prod));
    end
    @(negedge clk);
    wait_ready(4'b0100, ok);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    wait_rsp(lat, ok);
    n_checks++;
    if (!ok || rsp_prod !== 64'sd30 || rsp_id !== 2'd2) begin
      n_fails++;
      $display("FAIL midrst_rsp2: id=%0d prod=%0d expected id=2 prod=30", rsp_id, $signed(rsp_prod));
    end
  endtask

`ifdef BOOTH_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio;
    bit ok;
    int lat;
    @(negedge clk);
    drive(1, 32'sd6, 32'sd7);
    drive(3, -32'sd1, -32'sd1);
    for (int g = 0; g < 3; g++) begin
      wait_ready(4'b1010, ok);
      n_checks++;
      if (!ok || req_ready !== 4'b0010) begin
        n_fails++;
        $display("FAIL fixed_grant%0d: req_ready=%b expected 0010", g, req_ready);
      end
      @(posedge clk);
      wait_rsp(lat, ok);
      n_checks++;
      if (!ok || rsp_prod !== 64'sd42 || rsp_id !== 2'd1) begin
        n_fails++;
        $display("FAIL fixed_rsp%0d: id=%0d prod=%0d expected id=1 prod=42", g, rsp_id,
                 $signed(rsp_prod));
      end
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_ready(4'b1000, ok);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    wait_rsp(lat, ok);
    n_checks++;
    if (!ok || rsp_prod !== 64'sd1 || rsp_id !== 2'd3) begin
      n_fails++;
      $display("FAIL fixed_rsp3: id=%0d prod=%0d expected id=3 prod=1", rsp_id, $signed(rsp_prod));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_corners();
`ifndef BOOTH_ARB_FIXED_PRIO_EN
    test_round_robin();
`endif
    test_backpressure();
    test_reset_mid_busy();
`ifdef BOOTH_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
